// File: rtl/router_output_arbiter.sv
// ============================================================================
//  Module   : router_output_arbiter
//  Function : round-robin, packet-locked sharing of one output link among
//             NUM_PORTS input queues. Optional idle-owner timeout is enabled
//             by defining ROUTER_ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_output_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int FLIT_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit,
  input  logic [NUM_PORTS-1:0]            in_last,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic                            out_valid,
  output logic [FLIT_WIDTH-1:0]           out_flit,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic [$clog2(NUM_PORTS)-1:0]    out_src,
  output logic                            busy,
  output logic                            err_timeout
);

  localparam int c_PW = $clog2(NUM_PORTS);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  logic [c_PW-1:0]       r_ptr;
  logic [c_PW-1:0]       r_owner;

  logic                  w_found;
  logic [c_PW-1:0]       w_winner;
  logic [c_PW-1:0]       w_next_ptr;
  logic [NUM_PORTS-1:0]  w_owner_onehot;
  logic [FLIT_WIDTH-1:0] w_owner_flit;
  logic                  w_owner_valid;
  logic                  w_owner_last;
  logic                  w_locked;
  logic                  w_xfer;

  // (base + off) mod NUM_PORTS without a divider; off is always < NUM_PORTS
  function automatic logic [c_PW-1:0] f_wrap(input logic [c_PW-1:0] base,
                                             input int unsigned     off);
    logic [c_PW:0] sum;
    sum = {1'b0, base} + (c_PW+1)'(off);
    if (sum >= (c_PW+1)'(NUM_PORTS)) begin
      sum = sum - (c_PW+1)'(NUM_PORTS);
    end
    return sum[c_PW-1:0];
  endfunction

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!w_found && in_valid[f_wrap(r_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = f_wrap(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_owner_onehot = '0;
    w_owner_flit   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_owner == c_PW'(i)) begin
        w_owner_onehot[i] = 1'b1;
        w_owner_flit      = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end
  end

  assign w_owner_valid = |(in_valid & w_owner_onehot);
  assign w_owner_last  = |(in_last & w_owner_onehot);
  assign w_locked      = (r_state == S_LOCKED);
  assign w_next_ptr    = f_wrap(r_owner, 1);

  // The link is a pure pass-through of the owner while locked; zero otherwise
  assign out_valid = w_locked & w_owner_valid;
  assign out_last  = w_locked & w_owner_last;
  assign out_flit  = w_locked ? w_owner_flit : '0;
  assign in_ready  = (w_locked & out_ready) ? w_owner_onehot : '0;
  assign out_src   = r_owner;
  assign busy      = w_locked;
  assign w_xfer    = out_valid & out_ready;

`ifdef ROUTER_ARB_TIMEOUT_EN
  localparam int c_CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_CW-1:0] r_cnt;
  logic            r_err;
  assign err_timeout = r_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
  assign err_timeout  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
`ifdef ROUTER_ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
`ifdef ROUTER_ARB_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner <= w_winner;
            r_state <= S_LOCKED;
`ifdef ROUTER_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_LOCKED: begin
          if (w_xfer && out_last) begin
            r_state <= S_IDLE;
            r_ptr   <= w_next_ptr;
          end
`ifdef ROUTER_ARB_TIMEOUT_EN
          else if (w_owner_valid) begin
            r_cnt <= '0;
          end else if (r_cnt == c_CW'(TIMEOUT_CYCLES - 1)) begin
            // this silent cycle is the TIMEOUT_CYCLES-th: release the link
            r_state <= S_IDLE;
            r_ptr   <= w_next_ptr;
            r_err   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_router_output_arbiter.sv
// ============================================================================
//  Module   : tb_router_output_arbiter
//  Function : randomized scoreboard bench for router_output_arbiter
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_router_output_arbiter;

  localparam int NP = 4;
  localparam int FW = 32;
  localparam int PW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     in_valid;
  logic [NP*FW-1:0]  in_flit;
  logic [NP-1:0]     in_last;
  logic [NP-1:0]     in_ready;
  logic              out_valid;
  logic [FW-1:0]     out_flit;
  logic              out_last;
  logic              out_ready;
  logic [PW-1:0]     out_src;
  logic              busy;
  logic              err_timeout;

  router_output_arbiter #(
    .NUM_PORTS(NP), .FLIT_WIDTH(FW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flit(in_flit),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_flit(out_flit), .out_last(out_last), .out_ready(out_ready),
    .out_src(out_src), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] src;
    logic          last;
    logic [FW-1:0] flit;
  } exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [FW:0] fq [NP][$];   // per-port pending flits, bit FW = tail
  exp_t        sb [$];       // expected output transfers, in order
  int          mute [NP];
  bit          rdy_pat [$];
  int          gap_pct = 0;
  int          bp_pct  = 0;
  bit          m_free  = 1'b1;
  int          m_owner = 0;
  int          m_ptr   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    for (int i = 0; i < len; i++) fq[p].push_back({(i == len - 1), FW'($urandom)});
  endtask

  function automatic bit pending();
    bit r = 1'b0;
    for (int p = 0; p < NP; p++) if (fq[p].size() > 0) r = 1'b1;
    return r;
  endfunction

  // one clock: drive at negedge, check against the model, then advance the model
  task automatic step();
    logic [NP-1:0] exp_rdy;
    int            w;
    bit            tail;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      if (mute[p] > 0) begin
        in_valid[p] = 1'b0;
        mute[p]--;
      end else begin
        in_valid[p] = (fq[p].size() > 0) && ($urandom_range(99) >= gap_pct);
      end
      in_flit[p*FW +: FW] = (fq[p].size() > 0) ? fq[p][0][FW-1:0] : FW'($urandom);
      in_last[p]          = (fq[p].size() > 0) ? fq[p][0][FW] : 1'b0;
    end
    if (rdy_pat.size() > 0) out_ready = rdy_pat.pop_front();
    else                    out_ready = ($urandom_range(99) >= bp_pct);
    #2;
    exp_rdy = '0;
    if (!m_free && out_ready) exp_rdy[m_owner] = 1'b1;
    chk("busy", busy, !m_free);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, !m_free && in_valid[m_owner]);
    chk("err_timeout", err_timeout, 1'b0);
    if (!m_free) begin
      chk("out_src", out_src, m_owner);
      if (in_valid[m_owner]) begin
        chk("out_flit", out_flit, fq[m_owner][0][FW-1:0]);
        chk("out_last", out_last, fq[m_owner][0][FW]);
      end
    end
    if (m_free) begin
      w = -1;
      for (int k = 0; k < NP; k++)
        if (w < 0 && in_valid[(m_ptr + k) % NP]) w = (m_ptr + k) % NP;
      if (w >= 0) begin
        for (int i = 0; i < fq[w].size(); i++) begin
          sb.push_back('{src: PW'(w), last: fq[w][i][FW], flit: fq[w][i][FW-1:0]});
          if (fq[w][i][FW]) break;
        end
        m_free  = 1'b0;
        m_owner = w;
      end
    end else if (in_valid[m_owner] && out_ready) begin
      tail = fq[m_owner][0][FW];
      void'(fq[m_owner].pop_front());
      if (tail) begin
        m_ptr  = (m_owner + 1) % NP;
        m_free = 1'b1;
      end
    end
  endtask

  task automatic drain(input int max_cyc);
    int c = 0;
    while (c < max_cyc && pending()) begin
      step();
      c++;
    end
    step();
    step();
    if (c >= max_cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: actual=%0d cycles required=<%0d", c, max_cyc);
    end
    chk("sb_leftover", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, '0);
    chk("rst_out_flit", out_flit, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_src", out_src, '0);
    chk("rst_err_timeout", err_timeout, 1'b0);
    for (int p = 0; p < NP; p++) begin
      fq[p].delete();
      mute[p] = 0;
    end
    sb.delete();
    rdy_pat.delete();
    m_free   = 1'b1;
    m_ptr    = 0;
    m_owner  = 0;
    in_valid = '0;
    rst_n    = 1'b1;
  endtask

  // monitor: every real output transfer must match the next scoreboard entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: actual src=%0d flit=%0h required=no transfer", out_src, out_flit);
        end else begin
          e = sb.pop_front();
          chk("sb_src", out_src, e.src);
          chk("sb_flit", out_flit, e.flit);
          chk("sb_last", out_last, e.last);
        end
      end
    end
  end

  initial begin
    int c;
    in_valid = '0; in_flit = '0; in_last = '0; out_ready = 1'b0; rst_n = 1'b0;
    for (int p = 0; p < NP; p++) mute[p] = 0;
    do_reset();
    repeat (5) step();

    add_pkt(0, 3);
    add_pkt(2, 3);
    drain(50);

    do_reset();
    for (int p = 0; p < NP; p++) begin
      add_pkt(p, 1);
      add_pkt(p, 1);
    end
    drain(60);

    do_reset();
    add_pkt(1, 3);
    step();
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    drain(30);

    do_reset();
    add_pkt(3, 3);
    c = 0;
    while (fq[3].size() > 2 && c < 20) begin step(); c++; end
    add_pkt(0, 1);
    mute[3] = 4;
    repeat (4) step();
    drain(30);

    do_reset();
    add_pkt(0, 4);
    c = 0;
    while (fq[0].size() > 2 && c < 20) begin step(); c++; end
    do_reset();
    repeat (3) step();

    gap_pct = 20;
    bp_pct  = 30;
    repeat (80) begin
      for (int p = 0; p < NP; p++)
        if ($urandom_range(3) == 0) add_pkt(p, int'($urandom_range(4, 1)));
      repeat ($urandom_range(6, 1)) step();
    end
    drain(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/router_output_arbiter.md
Name: router_output_arbiter

Overview:
- Shares one router output link between NUM_PORTS input queues, with packet-level locking.
- Round-robin selection picks a winning port, then the link is locked to it until that packet's tail flit is accepted.
- Sits between the router's per-input FIFOs and a single output port (local or neighbour link) in the packet_controller datapath.

Parameters:
- NUM_PORTS, 4, number of requesting input ports (2..8)
- FLIT_WIDTH, 64, flit width in bits
- TIMEOUT_CYCLES, 16, idle-owner cycles before forced release (used only with ROUTER_ARB_TIMEOUT_EN)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  NUM_PORTS  per-port flit valid
- in_flit  input  NUM_PORTS*FLIT_WIDTH  per-port flit; port i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH]
- in_last  input  NUM_PORTS  per-port tail-flit marker
- in_ready  output  NUM_PORTS  per-port accept
- out_valid  output  1  output flit valid
- out_flit  output  FLIT_WIDTH  output flit
- out_last  output  1  output tail marker
- out_ready  input  1  downstream accept
- out_src  output  $clog2(NUM_PORTS)  index of the current owner
- busy  output  1  high while in LOCKED
- err_timeout  output  1  one-cycle pulse on forced release (tied 0 without the macro)

Behaviour:
- Reset: rst_n low at a clk edge → state IDLE, ptr=0, owner=0, all outputs 0. Reset mid-packet abandons the packet; there is no resume.
- States: IDLE, LOCKED.
- IDLE:
  - in_ready=0, out_valid=0.
  - If any in_valid is high, pick the first set bit scanning ptr, ptr+1, … wrapping modulo NUM_PORTS.
  - Register the winner into owner and go to LOCKED next cycle. This is a fixed 1-cycle arbitration bubble.
- LOCKED outputs (combinational):
  - out_valid = in_valid[owner]
  - out_flit = in_flit[owner]
  - out_last = in_last[owner]
  - in_ready[owner] = out_ready; all other in_ready bits = 0
  - out_src = owner, busy = 1
- Transfer: defined as out_valid && out_ready.
  - Transfer with out_last=1 → IDLE next cycle, ptr = (owner+1) mod NUM_PORTS.
  - Otherwise stay LOCKED.
- Single-flit packets: first flit has in_last=1; the port holds the link for exactly one transfer.
- Owner drops in_valid mid-packet: stay LOCKED with out_valid=0. No other port may interleave.
- Requester deasserts after being sampled in IDLE: grant is still taken; LOCKED waits for it.
- ptr changes only on tail transfer. Back-to-back packets from a single requester therefore incur a bubble, and other pending ports win in rotation first.
- No flit is duplicated or dropped: each in_ready&in_valid handshake maps to exactly one output transfer in the same cycle.
- out_ready low holds out_flit stable as long as the owner holds its input stable; the arbiter adds no storage.

Optional Feature:
- Macro: ROUTER_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each LOCKED cycle with in_valid[owner]=0 and clears on any owner valid flit or on entering LOCKED.
  - When the counter reaches TIMEOUT_CYCLES: force IDLE, set ptr=(owner+1) mod NUM_PORTS, and pulse err_timeout for 1 cycle.
  - Counter width is $clog2(TIMEOUT_CYCLES+1); counter resets to 0.
- Undefined: no counter; err_timeout is constant 0; LOCKED waits indefinitely.

Test Plan:
- Reset then in_valid=4'b0000 for 5 cycles → busy=0, out_valid=0, in_ready=0 every cycle.
- in_valid=4'b0101, both ports send 3-flit packets, out_ready=1 → port 0 owns first (out_src=0, 3 transfers, flits in order), 1 IDLE cycle, then port 2 (3 transfers), ptr=3.
- All 4 ports request continuously with 1-flit packets → grant order 0,1,2,3,0 with an IDLE cycle between each; no port is granted twice before the others.
- Port 1 packet, out_ready toggles 1,0,0,1,1 over a 3-flit packet → out_flit held stable while out_ready=0, in_ready[1] mirrors out_ready, exactly 3 transfers.
- Port 3 owner, in_valid[0]=1 and in_valid[3]=0 for 4 cycles mid-packet → out_valid=0, in_ready[0]=0, state stays LOCKED, out_src=3.
- Reset asserted mid-packet (after flit 2 of 4) → next cycle busy=0 and all outputs 0. With ROUTER_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, an owner silent for 16 cycles → err_timeout pulses once, busy=0, ptr=owner+1.
